gat_stage_sequencer: RTL and testbench

GAT_STAGE_SEQUENCER -- requirements
Module: gat_stage_sequencer

---
 rtl/gat_ctrl_pkg.sv | 26 ++
 rtl/gat_sat_counter.sv | 26 ++
 rtl/gat_stage_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_gat_stage_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gat_ctrl_pkg.sv
// Shared definitions for the GAT stage sequencer.
// Contains the state codes, which are also the stage_o encoding, and the watchdog width.
package gat_ctrl_pkg;

    localparam int WD_W    = 24;
    localparam int N_STAGE = 4;

    localparam logic [2:0] STAGE_IDLE = 3'd0;
    localparam logic [2:0] STAGE_SPMM = 3'd1;
    localparam logic [2:0] STAGE_DMVM = 3'd2;
    localparam logic [2:0] STAGE_SM   = 3'd3;
    localparam logic [2:0] STAGE_AGGR = 3'd4;
    localparam logic [2:0] STAGE_DONE = 3'd5;
    localparam logic [2:0] STAGE_ERR  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE = STAGE_IDLE,
        ST_SPMM = STAGE_SPMM,
        ST_DMVM = STAGE_DMVM,
        ST_SM   = STAGE_SM,
        ST_AGGR = STAGE_AGGR,
        ST_DONE = STAGE_DONE,
        ST_ERR  = STAGE_ERR
    } state_t;

endpackage

// File: rtl/gat_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over enable).
module gat_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/gat_stage_sequencer.sv
// Sequences SPMM -> DMVM -> SM -> AGGR per GAT layer with a per-stage watchdog.
// Define GAT_PERF_CNT_EN to enable the per-stage cycle counters (otherwise *_cyc_o read 0).
import gat_ctrl_pkg::*;

module gat_stage_sequencer #(
    parameter int N_LAYER = 2,
    parameter int TIMEOUT = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        spmm_en_o,
    output logic        dmvm_en_o,
    output logic        sm_en_o,
    output logic        aggr_en_o,
    input  logic        spmm_rdy_i,
    input  logic        dmvm_rdy_i,
    input  logic        sm_rdy_i,
    input  logic        aggr_rdy_i,
    input  logic        spmm_vld_i,
    input  logic        dmvm_vld_i,
    input  logic        sm_vld_i,
    input  logic        aggr_vld_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  stage_o,
    output logic [1:0]  layer_o,
    output logic [31:0] spmm_cyc_o,
    output logic [31:0] dmvm_cyc_o,
    output logic [31:0] sm_cyc_o,
    output logic [31:0] aggr_cyc_o
);

    localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(TIMEOUT);
    localparam logic [1:0]      LAST_LAYER = 2'(N_LAYER - 1);

    state_t            state_reg, state_next;
    logic              wait_reg, wait_next;
    logic [1:0]        layer_reg, layer_next;
    logic [WD_W-1:0]   wd_reg, wd_next, wd_inc;
    logic [N_STAGE-1:0] en_reg, en_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              cur_rdy, cur_vld;

    always_comb begin
        cur_rdy = 1'b0;
        cur_vld = 1'b0;
        case (state_reg)
            ST_SPMM: begin cur_rdy = spmm_rdy_i; cur_vld = spmm_vld_i; end
            ST_DMVM: begin cur_rdy = dmvm_rdy_i; cur_vld = dmvm_vld_i; end
            ST_SM:   begin cur_rdy = sm_rdy_i;   cur_vld = sm_vld_i;   end
            ST_AGGR: begin cur_rdy = aggr_rdy_i; cur_vld = aggr_vld_i; end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        layer_next = layer_reg;
        wd_next    = wd_reg;
        wd_inc     = wd_reg + WD_W'(1);

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_SPMM;
                    wait_next  = 1'b0;
                    layer_next = 2'd0;
                    wd_next    = '0;
                end
            end
            ST_SPMM, ST_DMVM, ST_SM, ST_AGGR: begin
                wd_next = wd_inc;
                // Watchdog expiry outranks a completion arriving in the same cycle.
                if (wd_inc == WD_LIMIT) begin
                    state_next = ST_ERR;
                end else if (!wait_reg) begin
                    if (cur_rdy) wait_next = 1'b1;
                end else if (cur_vld) begin
                    wait_next = 1'b0;
                    wd_next   = '0;
                    case (state_reg)
                        ST_SPMM: state_next = ST_DMVM;
                        ST_DMVM: state_next = ST_SM;
                        ST_SM:   state_next = ST_AGGR;
                        default: begin
                            if (layer_reg == LAST_LAYER) begin
                                state_next = ST_DONE;
                            end else begin
                                state_next = ST_SPMM;
                                layer_next = layer_reg + 2'd1;
                            end
                        end
                    endcase
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  ;
            default: state_next = ST_IDLE;
        endcase

        if (abort_i) begin
            state_next = ST_IDLE;
            wait_next  = 1'b0;
        end

        en_next = '0;
        if (!wait_next) begin
            case (state_next)
                ST_SPMM: en_next[0] = 1'b1;
                ST_DMVM: en_next[1] = 1'b1;
                ST_SM:   en_next[2] = 1'b1;
                ST_AGGR: en_next[3] = 1'b1;
                default: ;
            endcase
        end
        busy_next = (state_next != ST_IDLE) && (state_next != ST_ERR);
        done_next = (state_next == ST_DONE);
        err_next  = (state_next == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            wait_reg  <= 1'b0;
            layer_reg <= 2'd0;
            wd_reg    <= '0;
            en_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            layer_reg <= layer_next;
            wd_reg    <= wd_next;
            en_reg    <= en_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign spmm_en_o = en_reg[0];
    assign dmvm_en_o = en_reg[1];
    assign sm_en_o   = en_reg[2];
    assign aggr_en_o = en_reg[3];
    assign busy_o    = busy_reg;
    assign done_o    = done_reg;
    assign err_o     = err_reg;
    assign stage_o   = state_reg;
    assign layer_o   = layer_reg;

`ifdef GAT_PERF_CNT_EN
    logic        cnt_clr;
    logic [31:0] cyc [N_STAGE];

    assign cnt_clr = (state_reg == ST_IDLE) && start_i && !abort_i;

    generate
        for (genvar gi = 0; gi < N_STAGE; gi++) begin : g_cyc
            gat_sat_counter #(.W(32)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (cnt_clr),
                .en    (state_reg == state_t'(gi + 1)),
                .count (cyc[gi])
            );
        end
    endgenerate

    assign spmm_cyc_o = cyc[0];
    assign dmvm_cyc_o = cyc[1];
    assign sm_cyc_o   = cyc[2];
    assign aggr_cyc_o = cyc[3];
`else
    assign spmm_cyc_o = 32'd0;
    assign dmvm_cyc_o = 32'd0;
    assign sm_cyc_o   = 32'd0;
    assign aggr_cyc_o = 32'd0;
`endif

endmodule

// File: tb/tb_gat_stage_sequencer.sv
// Self-checking bench for gat_stage_sequencer: timeline reference model plus directed scenarios.
module tb_gat_stage_sequencer;

    localparam int NL = 2;
    localparam int TO = 16;
    localparam int NV = 4 * NL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [3:0]  rdy = 4'h0;
    logic [3:0]  vld = 4'h0;
    logic        spmm_en_o, dmvm_en_o, sm_en_o, aggr_en_o;
    logic        busy_o, done_o, err_o;
    logic [2:0]  stage_o;
    logic [1:0]  layer_o;
    logic [31:0] spmm_cyc_o, dmvm_cyc_o, sm_cyc_o, aggr_cyc_o;

    logic [11:0] obs;
    logic [31:0] cyc_obs [4];

    int n_tests = 0;
    int n_fail  = 0;
    int rd [NV];
    int vd [NV];

    always #5 clk = ~clk;

    gat_stage_sequencer #(.N_LAYER(NL), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .spmm_en_o  (spmm_en_o),
        .dmvm_en_o  (dmvm_en_o),
        .sm_en_o    (sm_en_o),
        .aggr_en_o  (aggr_en_o),
        .spmm_rdy_i (rdy[0]),
        .dmvm_rdy_i (rdy[1]),
        .sm_rdy_i   (rdy[2]),
        .aggr_rdy_i (rdy[3]),
        .spmm_vld_i (vld[0]),
        .dmvm_vld_i (vld[1]),
        .sm_vld_i   (vld[2]),
        .aggr_vld_i (vld[3]),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .stage_o    (stage_o),
        .layer_o    (layer_o),
        .spmm_cyc_o (spmm_cyc_o),
        .dmvm_cyc_o (dmvm_cyc_o),
        .sm_cyc_o   (sm_cyc_o),
        .aggr_cyc_o (aggr_cyc_o)
    );

    // {aggr,sm,dmvm,spmm en, stage, layer, busy, done, err}
    assign obs = {aggr_en_o, sm_en_o, dmvm_en_o, spmm_en_o, stage_o, layer_o, busy_o, done_o, err_o};
    assign cyc_obs[0] = spmm_cyc_o;
    assign cyc_obs[1] = dmvm_cyc_o;
    assign cyc_obs[2] = sm_cyc_o;
    assign cyc_obs[3] = aggr_cyc_o;

    task automatic test_reset();
        rst_n = 1'b0;
        start_i = 1'b0; abort_i = 1'b0; rdy = 4'h0; vld = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs, 12'h000);
        end
        n_tests++;
        if ({spmm_cyc_o, dmvm_cyc_o, sm_cyc_o, aggr_cyc_o} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_cyc: got %h %h %h %h want 0", spmm_cyc_o, dmvm_cyc_o, sm_cyc_o, aggr_cyc_o);
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] reset checked");
    endtask

    // Expected behaviour derived from a timeline: visit j starts at t[j], spends rd[j]+1
    // cycles requesting and vd[j] cycles waiting; DONE follows the last visit.
    task automatic run_timeline(input string tag);
        int t [NV+1];
        int exp_cyc [4];
        int tt, jj, s;
        logic [3:0]  e_en;
        logic [2:0]  e_st;
        logic [1:0]  e_ly;
        logic        e_busy, e_done;
        logic [11:0] e_obs;

        t[0] = 1;
        for (int i = 0; i < 4; i++) exp_cyc[i] = 0;
        for (int j = 0; j < NV; j++) begin
            t[j+1] = t[j] + rd[j] + 1 + vd[j];
            exp_cyc[j % 4] += rd[j] + 1 + vd[j];
        end
        tt = t[NV];

        start_i = 1'b1; abort_i = 1'b0; rdy = 4'h0; vld = 4'h0;
        for (int c = 1; c <= tt + 1; c++) begin
            @(posedge clk);
            #1;
            start_i = (c < tt) ? ($urandom_range(0, 3) == 0) : 1'b0;
            rdy = 4'($urandom);
            vld = 4'h0;
            jj = -1;
            for (int j = 0; j < NV; j++) begin
                if (t[j] <= c && c < t[j+1]) jj = j;
            end
            e_en = 4'h0; e_busy = 1'b0; e_done = 1'b0;
            e_ly = 2'(NL - 1);
            e_st = 3'd0;
            if (jj >= 0) begin
                s = jj % 4;
                e_st = 3'(s + 1);
                e_ly = 2'(jj / 4);
                e_busy = 1'b1;
                if (c < t[jj] + rd[jj] + 1) begin
                    e_en = 4'(1 << s);
                    rdy[s] = (c == t[jj] + rd[jj]);
                    vld[s] = 1'($urandom_range(0, 1));
                end else begin
                    vld[s] = (c == t[jj+1] - 1);
                end
            end else if (c == tt) begin
                e_st = 3'd5; e_busy = 1'b1; e_done = 1'b1;
                rdy = 4'h0;
            end
            e_obs = {e_en, e_st, e_ly, e_busy, e_done, 1'b0};
            n_tests++;
            if (obs !== e_obs) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h want %h", tag, c, obs, e_obs);
            end
        end
        start_i = 1'b0; rdy = 4'h0; vld = 4'h0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
`ifdef GAT_PERF_CNT_EN
            if (cyc_obs[i] !== 32'(exp_cyc[i])) begin
                n_fail++;
                $display("FAIL %s cyc[%0d]: got %0d want %0d", tag, i, cyc_obs[i], exp_cyc[i]);
            end
`else
            if (cyc_obs[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL %s cyc[%0d]: got %0d want 0", tag, i, cyc_obs[i]);
            end
`endif
        end
        $display("[TB] %s: run of %0d cycles checked", tag, tt + 1);
    endtask

    task automatic test_basic();
        for (int j = 0; j < NV; j++) begin rd[j] = 0; vd[j] = 3; end
        run_timeline("basic");
    endtask

    task automatic test_rdy_stall();
        for (int j = 0; j < NV; j++) begin rd[j] = 0; vd[j] = 1; end
        rd[1] = 5;
        run_timeline("rdy_stall");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < NV; j++) begin
                rd[j] = int'($urandom_range(0, 4));
                vd[j] = int'($urandom_range(1, 5));
            end
            run_timeline($sformatf("random%0d", r));
        end
    endtask

    task automatic test_timeout();
        logic [11:0] e_obs;
        logic        chk;
        int          e_cyc [4];
        e_cyc[0] = 2; e_cyc[1] = 2; e_cyc[2] = 16; e_cyc[3] = 0;
        start_i = 1'b1; abort_i = 1'b0; rdy = 4'hF; vld = 4'h0;
        for (int c = 1; c <= 26; c++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0; abort_i = 1'b0; vld = 4'h0;
            if (c == 2) vld[0] = 1'b1;
            if (c == 4) vld[1] = 1'b1;
            if (c >= 22 && c <= 24) begin start_i = 1'b1; vld = 4'hF; end
            if (c == 25) abort_i = 1'b1;
            chk = 1'b1;
            e_obs = 12'h000;
            if (c == 5)                 e_obs = {4'b0100, 3'd3, 2'd0, 3'b100};
            else if (c == 20)           e_obs = {4'b0000, 3'd3, 2'd0, 3'b100};
            else if (c == 21 || c == 24) e_obs = {4'b0000, 3'd6, 2'd0, 3'b001};
            else if (c == 26)           e_obs = {4'b0000, 3'd0, 2'd0, 3'b000};
            else chk = 1'b0;
            if (chk) begin
                n_tests++;
                if (obs !== e_obs) begin
                    n_fail++;
                    $display("FAIL timeout cycle %0d: got %h want %h", c, obs, e_obs);
                end
            end
        end
        start_i = 1'b0; rdy = 4'h0; vld = 4'h0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
`ifdef GAT_PERF_CNT_EN
            if (cyc_obs[i] !== 32'(e_cyc[i])) begin
                n_fail++;
                $display("FAIL timeout cyc[%0d]: got %0d want %0d", i, cyc_obs[i], e_cyc[i]);
            end
`else
            if (cyc_obs[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL timeout cyc[%0d]: got %0d want 0 (%0d with counters)", i, cyc_obs[i], e_cyc[i]);
            end
`endif
        end
        $display("[TB] timeout: ERR entry and abort checked");
    endtask

    task automatic test_abort();
        logic [11:0] e_obs;
        start_i = 1'b1; abort_i = 1'b1; rdy = 4'hF; vld = 4'h0;
        @(posedge clk);
        #1;
        start_i = 1'b0; abort_i = 1'b0;
        n_tests++;
        if ({obs[11:5], obs[2:0]} !== 10'h000) begin
            n_fail++;
            $display("FAIL abort_vs_start: got %h want en/stage/flags all 0", obs);
        end
        start_i = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0; abort_i = 1'b0; vld = 4'h0;
            if (c == 2) vld[0] = 1'b1;
            if (c == 3) start_i = 1'b1;
            if (c == 4) vld[1] = 1'b1;
            if (c == 6) vld[2] = 1'b1;
            if (c == 9) abort_i = 1'b1;
            if (c >= 10) vld[3] = 1'b1;
            e_obs = {4'b0000, 3'd0, 2'd0, 3'b000};
            if (c == 4)      e_obs = {4'b0000, 3'd2, 2'd0, 3'b100};
            else if (c == 7) e_obs = {4'b1000, 3'd4, 2'd0, 3'b100};
            else if (c == 9) e_obs = {4'b0000, 3'd4, 2'd0, 3'b100};
            if (c == 4 || c == 7 || c >= 9) begin
                n_tests++;
                if (obs !== e_obs) begin
                    n_fail++;
                    $display("FAIL abort cycle %0d: got %h want %h", c, obs, e_obs);
                end
            end
        end
        rdy = 4'h0; vld = 4'h0;
        n_tests++;
`ifdef GAT_PERF_CNT_EN
        if (aggr_cyc_o !== 32'd3 || spmm_cyc_o !== 32'd2) begin
            n_fail++;
            $display("FAIL abort_cyc: got aggr %0d spmm %0d want 3 2", aggr_cyc_o, spmm_cyc_o);
        end
`else
        if (aggr_cyc_o !== 32'd0 || spmm_cyc_o !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_cyc: got aggr %0d spmm %0d want 0 0", aggr_cyc_o, spmm_cyc_o);
        end
`endif
        $display("[TB] abort: idle collision and mid-AGGR abort checked");
    endtask

    task automatic test_reset_midrun();
        start_i = 1'b1; abort_i = 1'b0; rdy = 4'b1101; vld = 4'h0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0; vld = 4'h0;
            if (c == 2) vld[0] = 1'b1;
        end
        n_tests++;
        if (obs !== {4'b0010, 3'd2, 2'd0, 3'b100}) begin
            n_fail++;
            $display("FAIL midrun_pre: got %h want %h", obs, {4'b0010, 3'd2, 2'd0, 3'b100});
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== 12'h000 || {spmm_cyc_o, dmvm_cyc_o, sm_cyc_o, aggr_cyc_o} !== 128'h0) begin
            n_fail++;
            $display("FAIL midrun_async_reset: got %h want 000 with zero cycle counts", obs);
        end
        #1 rst_n = 1'b1;
        rdy = 4'h0;
        for (int j = 0; j < NV; j++) begin
            rd[j] = int'($urandom_range(0, 3));
            vd[j] = int'($urandom_range(1, 4));
        end
        run_timeline("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rdy_stall();
        test_random();
        test_timeout();
        test_abort();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1);
    end

endmodule
